// File: rtl/ifetch_prefetch.sv
// Instruction fetch stage: owns the fetch PC, runs a single-outstanding req/ack
// fetch to instruction memory and buffers words in a small prefetch FIFO.
// Optional stall counter port enabled by defining IFETCH_PERF_EN.
module ifetch_prefetch #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_STEP = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ack,
  input  logic [15:0]              imem_rdata,
  output logic                     ir_valid,
  output logic [15:0]              ir,
  output logic [ADDR_W-1:0]        ir_pc,
  input  logic                     ir_ready,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   fpc_q;
  logic                req_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         word_q [DEPTH];
  logic [ADDR_W-1:0]   pc_q   [DEPTH];
  logic [PTR_W-1:0]    wptr_q;
  logic [PTR_W-1:0]    rptr_q;
  logic [CNT_W-1:0]    count_q;

  logic                push_c;
  logic                pop_c;
  logic                space_c;
  logic [CNT_W-1:0]    count_d;
  logic [ADDR_W-1:0]   rpc_c;
  logic [ADDR_W-1:0]   fpc_inc_c;

  // Occupancy after this cycle's push/pop decides whether another fetch may issue.
  always_comb begin
    pop_c     = (count_q != '0) && ir_ready;
    push_c    = (state_q == S_REQ) && imem_ack && !redirect;
    count_d   = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    space_c   = count_d < CNT_W'(DEPTH);
    rpc_c     = redirect_pc & ~ADDR_W'(1);
    fpc_inc_c = fpc_q + ADDR_W'(PC_STEP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      fpc_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      // A redirect flushes the FIFO and overrides any push or pop.
      if (redirect) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push_c) begin
          word_q[wptr_q] <= imem_rdata;
          pc_q[wptr_q]   <= fpc_q;
          wptr_q         <= wptr_q + PTR_W'(1);
        end
        if (pop_c) begin
          rptr_q <= rptr_q + PTR_W'(1);
        end
        count_q <= count_d;
      end

      unique case (state_q)
        S_IDLE: begin
          if (redirect) begin
            fpc_q <= rpc_c;
          end else if (space_c) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            addr_q  <= fpc_q;
          end
        end
        S_REQ: begin
          if (redirect) begin
            fpc_q <= rpc_c;
            if (imem_ack) begin
              addr_q <= rpc_c;
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (imem_ack) begin
            fpc_q <= fpc_inc_c;
            if (space_c) begin
              addr_q <= fpc_inc_c;
            end else begin
              state_q <= S_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        // Stale request stays on the bus until the memory acks it; its data is dropped.
        S_DRAIN: begin
          if (redirect) begin
            fpc_q <= rpc_c;
          end
          if (imem_ack) begin
            state_q <= S_REQ;
            addr_q  <= redirect ? rpc_c : fpc_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign ir_valid   = (count_q != '0);
  assign ir         = word_q[rptr_q];
  assign ir_pc      = pc_q[rptr_q];
  assign fifo_count = count_q;

`ifdef IFETCH_PERF_EN
  logic [15:0] stall_q;

  // Cycles where the consumer is ready but nothing is available; saturating.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (ir_ready && !ir_valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: a directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level fetch model.
module tb_ifetch_prefetch;

  localparam int unsigned DEPTH = 4;

  logic        clock;
  logic        reset_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        ir_valid;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [2:0]  fifo_count;
`ifdef IFETCH_PERF_EN
  logic [15:0] stall_cnt;
`endif

  ifetch_prefetch #(.ADDR_W(16), .DEPTH(DEPTH), .PC_STEP(2)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ir_valid    (ir_valid),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fifo_count  (fifo_count)
`ifdef IFETCH_PERF_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  int          m_count;
  logic [15:0] m_fpc;
  logic [15:0] m_exp;
  int          m_stall;
  bit          mem_busy;
  bit          mem_stale;
  int          mem_cnt;
  logic [15:0] mem_addr;
  int          mem_lat;
  bit          rand_lat;

  typedef struct {
    logic        ack;
    logic [15:0] ra;
    logic        rdy;
    logic        rdr;
    logic [15:0] rpc;
    logic        e_req;
    logic        e_addr_care;
    logic [15:0] e_addr;
    logic [2:0]  e_count;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vecs [19];

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  function automatic vec_t mk(input logic ack, input logic [15:0] ra, input logic rdy,
                              input logic rdr, input logic [15:0] rpc, input logic er,
                              input logic ec, input logic [15:0] ea, input logic [2:0] cnt,
                              input logic [15:0] ep);
    vec_t v;
    v.ack = ack; v.ra = ra; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
    v.e_req = er; v.e_addr_care = ec; v.e_addr = ea; v.e_count = cnt; v.e_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_fpc = '0; m_exp = '0; m_stall = 0;
    mem_busy = 0; mem_stale = 0; mem_cnt = 0; mem_addr = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    ir_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req",   32'(imem_req),   32'd0);
    chk("rst_addr",  32'(imem_addr),  32'd0);
    chk("rst_valid", 32'(ir_valid),   32'd0);
    chk("rst_ir",    32'(ir),         32'd0);
    chk("rst_ir_pc", 32'(ir_pc),      32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
`ifdef IFETCH_PERF_EN
    chk("rst_stall", 32'(stall_cnt), 32'd0);
`endif
    reset_n = 1'b1;
    model_reset();
  endtask

  // One clock of model-driven operation: check, play memory, drive inputs, advance model.
  task automatic cycle(input logic rdy, input logic rdr, input logic [15:0] rpc);
    bit ack_live;
    bit pop;
    @(posedge clock);
    #1;
    chk("fifo_count", 32'(fifo_count), 32'(m_count));
    chk("ir_valid", 32'(ir_valid), 32'(m_count != 0));
    if (m_count == DEPTH) chk("req_when_full", 32'(imem_req), 32'd0);
`ifdef IFETCH_PERF_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    imem_ack = 1'b0;
    ack_live = 0;
    if (mem_busy) begin
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_held", 32'(imem_addr), 32'(mem_addr));
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = word_of(mem_addr);
        mem_busy   = 0;
        ack_live   = !mem_stale && !rdr;
      end
    end else if (imem_req) begin
      chk("fetch_addr", 32'(imem_addr), 32'(m_fpc));
      mem_busy  = 1;
      mem_stale = 0;
      mem_addr  = imem_addr;
      mem_cnt   = rand_lat ? int'($urandom_range(4, 1)) : mem_lat;
    end
    pop = ir_valid && rdy && !rdr;
    if (pop) begin
      chk("ir_pc", 32'(ir_pc), 32'(m_exp));
      chk("ir", 32'(ir), 32'(word_of(m_exp)));
      m_exp = m_exp + 16'd2;
    end
    if (rdy && m_count == 0) m_stall++;
    if (rdr) begin
      m_count = 0;
      m_fpc   = rpc & 16'hFFFE;
      m_exp   = m_fpc;
      if (mem_busy) mem_stale = 1;
    end else begin
      if (ack_live) begin
        m_count++;
        m_fpc = m_fpc + 16'd2;
      end
      if (pop) m_count--;
    end
    ir_ready = rdy; redirect = rdr; redirect_pc = rpc;
  endtask

  initial begin
    // ack, rdata-addr, ready, redirect, rpc | req, addr-care, addr, count, head pc
    vecs[0]  = mk(0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0000, 3'd0, 16'h0000);
    vecs[1]  = mk(1, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0002, 3'd1, 16'h0000);
    vecs[2]  = mk(1, 16'h0002, 0, 0, 16'h0000, 1, 1, 16'h0004, 3'd2, 16'h0000);
    vecs[3]  = mk(1, 16'h0004, 0, 0, 16'h0000, 1, 1, 16'h0006, 3'd3, 16'h0000);
    vecs[4]  = mk(1, 16'h0006, 0, 0, 16'h0000, 0, 0, 16'h0000, 3'd4, 16'h0000);
    vecs[5]  = mk(1, 16'h0008, 0, 0, 16'h0000, 0, 0, 16'h0000, 3'd4, 16'h0000);
    vecs[6]  = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0008, 3'd3, 16'h0002);
    vecs[7]  = mk(1, 16'h0008, 1, 0, 16'h0000, 1, 1, 16'h000A, 3'd3, 16'h0004);
    vecs[8]  = mk(1, 16'h000A, 1, 1, 16'h0101, 1, 1, 16'h0100, 3'd0, 16'h0000);
    vecs[9]  = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0100, 3'd0, 16'h0000);
    vecs[10] = mk(1, 16'h0100, 0, 0, 16'h0000, 1, 1, 16'h0102, 3'd1, 16'h0100);
    vecs[11] = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0102, 3'd0, 16'h0000);
    vecs[12] = mk(0, 16'h0000, 1, 1, 16'hFFFC, 1, 1, 16'h0102, 3'd0, 16'h0000);
    vecs[13] = mk(1, 16'h0102, 1, 0, 16'h0000, 1, 1, 16'hFFFC, 3'd0, 16'h0000);
    vecs[14] = mk(1, 16'hFFFC, 0, 0, 16'h0000, 1, 1, 16'hFFFE, 3'd1, 16'hFFFC);
    vecs[15] = mk(1, 16'hFFFE, 0, 0, 16'h0000, 1, 1, 16'h0000, 3'd2, 16'hFFFC);
    vecs[16] = mk(1, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0002, 3'd2, 16'hFFFE);
    vecs[17] = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0002, 3'd1, 16'h0000);
    vecs[18] = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0002, 3'd0, 16'h0000);

    mem_lat = 1; rand_lat = 0;
    do_reset();

    // Directed table: fill, full stall, spurious ack, drain, redirects, wrap.
    for (int i = 0; i < 19; i++) begin
      imem_ack    = vecs[i].ack;
      imem_rdata  = word_of(vecs[i].ra);
      ir_ready    = vecs[i].rdy;
      redirect    = vecs[i].rdr;
      redirect_pc = vecs[i].rpc;
      @(posedge clock);
      #1;
      chk($sformatf("t_req[%0d]", i), 32'(imem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_addr_care)
        chk($sformatf("t_addr[%0d]", i), 32'(imem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("t_count[%0d]", i), 32'(fifo_count), 32'(vecs[i].e_count));
      chk($sformatf("t_valid[%0d]", i), 32'(ir_valid), 32'(vecs[i].e_count != 0));
      if (vecs[i].e_count != 0) begin
        chk($sformatf("t_ir_pc[%0d]", i), 32'(ir_pc), 32'(vecs[i].e_pc));
        chk($sformatf("t_ir[%0d]", i), 32'(ir), 32'(word_of(vecs[i].e_pc)));
      end
    end

    // First-fetch latency with a 1-cycle memory and an always-ready consumer.
    mem_lat = 1; rand_lat = 0;
    do_reset();
    cycle(1, 0, '0); chk("lat_valid_c1", 32'(ir_valid), 32'd0);
    cycle(1, 0, '0); chk("lat_valid_c2", 32'(ir_valid), 32'd0);
    cycle(1, 0, '0); chk("lat_valid_c3", 32'(ir_valid), 32'd1);
    repeat (20) cycle(1, 0, '0);

    // Backpressure: FIFO fills and fetch stops, then drains in order.
    repeat (20) cycle(0, 0, '0);
    chk("bp_full_count", 32'(fifo_count), 32'(DEPTH));
    chk("bp_full_req", 32'(imem_req), 32'd0);
    repeat (30) cycle(1, 0, '0);

    // Slow memory, redirect while the request is pending.
    mem_lat = 5;
    do_reset();
    repeat (2) cycle(1, 0, '0);
    cycle(1, 1, 16'h0040);
    repeat (30) cycle(1, 0, '0);

    // Two redirects while draining; the later target wins.
    do_reset();
    repeat (2) cycle(1, 0, '0);
    cycle(1, 1, 16'h0200);
    cycle(1, 1, 16'h0301);
    repeat (30) cycle(1, 0, '0);

    // Reset in the middle of an outstanding request, followed by a late ack.
    mem_lat = 4;
    do_reset();
    repeat (3) cycle(1, 0, '0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req",   32'(imem_req),   32'd0);
    chk("mid_rst_addr",  32'(imem_addr),  32'd0);
    chk("mid_rst_valid", 32'(ir_valid),   32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    @(posedge clock);
    #1;
    reset_n    = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = word_of(16'h0006);
    ir_ready   = 1'b0;
    redirect   = 1'b0;
    model_reset();
    repeat (30) cycle(1, 0, '0);

    // Randomized traffic: variable latency, random consumer, occasional redirects.
    rand_lat = 1;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        rdy;
      logic        rdr;
      logic [15:0] rpc;
      rdy = ($urandom_range(9, 0) < 7);
      rdr = ($urandom_range(19, 0) == 0);
      if ($urandom_range(3, 0) == 0) rpc = 16'hFFF0 | 16'($urandom_range(15, 0));
      else                           rpc = 16'($urandom);
      cycle(rdy, rdr, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
- Instruction fetch stage directly upstream of the 16-bit single-cycle datapath.
- Owns the fetch PC and runs a req/ack handshake to a variable-latency instruction memory.
- Buffers fetched words in a small prefetch FIFO and presents {ir, ir_pc} to the decode/execute stage with valid/ready.
- Supports taken-branch/jump redirects with flush and discard of in-flight fetches.

Parameters:
- ADDR_W, 16, width of the fetch PC and memory address (byte address).
- DEPTH, 4, prefetch FIFO entries; must be a power of 2 and at least 2.
- PC_STEP, 2, byte increment per 16-bit instruction.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; registered.
- imem_addr  out  ADDR_W  fetch address; registered, stable while imem_req=1.
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  in  16  instruction word.
- ir_valid  out  1  FIFO head valid (count != 0).
- ir  out  16  head instruction.
- ir_pc  out  ADDR_W  byte address of the head instruction.
- ir_ready  in  1  consumer accepts the head this cycle.
- redirect  in  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address; bit 0 is forced to 0.
- fifo_count  out  log2(DEPTH)+1  current number of valid entries.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - fetch PC fpc=0; FIFO empty; state=IDLE.
  - imem_req=0, imem_addr=0, ir_valid=0, ir=0, ir_pc=0, fifo_count=0.
- Outstanding requests: at most one. Memory handshake: imem_req and imem_addr are held until the cycle imem_ack=1; the request is complete in that cycle.
- Space rule: a new request may issue only when count + (incoming push this cycle) - (pop this cycle) < DEPTH. The FIFO therefore never overflows.
- FSM:
  - IDLE: when no redirect and space allows -> REQ; next cycle imem_req=1, imem_addr=fpc.
  - REQ, no ack: hold request.
  - REQ, ack, no redirect: push {imem_rdata, fpc}; fpc += PC_STEP. If space remains, stay in REQ with imem_addr=new fpc next cycle (back-to-back, no bubble). Otherwise go to IDLE with imem_req=0.
  - REQ, redirect, no ack: flush FIFO; fpc=redirect_pc -> DRAIN. Keep imem_req=1 at the old address.
  - REQ, redirect and ack in the same cycle: discard rdata; flush; fpc=redirect_pc -> REQ at redirect_pc.
  - DRAIN: hold the old request until ack. Discard rdata, then -> REQ at fpc.
  - DRAIN, redirect again: update fpc; stay in DRAIN.
  - IDLE, redirect: flush; fpc=redirect_pc; re-evaluate space next cycle.
- Pop: occurs when ir_valid && ir_ready. Push and pop in the same cycle leave count unchanged. A redirect overrides push and pop; count=0 next cycle.
- Output timing:
  - ir/ir_pc come from the FIFO head storage; ir_valid = (count != 0).
  - Latency: ack in cycle N into an empty FIFO gives ir_valid=1 in cycle N+1.
  - With a 1-cycle memory and a permanently ready consumer, throughput is one instruction every 2 cycles (req registered, ack, push).
- Wrap-around:
  - fpc wraps modulo 2^ADDR_W (0xFFFE + 2 -> 0x0000).
  - FIFO read/write pointers wrap modulo DEPTH.
- Reset mid-transaction: imem_req drops immediately. The memory must abandon the request, and an ack arriving after reset is ignored (state IDLE, no outstanding request).
- imem_ack while imem_req=0 (outside DRAIN): ignored.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined:
  - Adds output port stall_cnt (16 bits).
  - Increments each cycle where ir_ready=1 && ir_valid=0; saturates at 0xFFFF.
  - Cleared by reset_n only; not cleared by redirect.
- Not defined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset, 1-cycle-latency memory returning word = addr, ir_ready=1 -> ir_pc sequence 0x0000, 0x0002, 0x0004…; ir matches; first ir_valid 3 cycles after reset release.
- ir_ready=0, memory always acks -> fifo_count rises to 4; imem_req stays 0 while full; no entry lost. Set ir_ready=1 -> entries drain in order, then fetch resumes.
- Memory latency 5 cycles; redirect to 0x0040 in the 2nd wait cycle -> imem_addr held until ack; that word is dropped; next imem_addr=0x0040; first ir_pc after redirect=0x0040.
- Redirect to 0x0101 in the same cycle as ack -> rdata discarded; fifo_count=0 next cycle; next request at 0x0100.
- Redirect to 0xFFFC -> ir_pc 0xFFFC, 0xFFFE, 0x0000 (wrap).
- reset_n pulsed low while imem_req=1 -> all outputs 0 immediately; a late ack is ignored; fetch restarts at 0x0000. With IFETCH_PERF_EN defined, stall_cnt counts empty-and-ready cycles (e.g. 5-cycle latency from reset -> 6 before the first ir_valid).
